occ_scan_sequencer: RTL
=======================

Name: occ_scan_sequencer

Overview:
- Scan-side counterpart to the on-chip clock controller. It drives the scan-enable waveform the OCC consumes: shift phase, then se low for the capture window, then back to shift.
- It monitors the OCC's capture-enable (`cap_en`) and checks that each capture window produced the expected pulse count: 2 in at-speed mode, 1 otherwise.
- It sits between the test-control TAP/ATE interface and the OCC, running on the fast clock domain.

Parameters:
- CHAIN_LEN, 16, shift cycles per pattern load/unload (≥2)
- CAP_WIN, 12, fclk cycles se is held low per capture window (≥10)
- SETTLE, 2, idle fclk cycles on each side of the capture window (≥1)
- PAT_W, 8, width of pattern count and index

Ports:
- fclk  in  1  sequencer clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- num_pat  in  PAT_W  patterns to run; 0 = start ignored
- ats_mode  in  1  captured at start; selects expected pulses (1 → 2, 0 → 1)
- cap_en  in  1  OCC capture-enable observed in fclk domain
- se  out  1  scan enable to OCC
- shift_en  out  1  high on each shift cycle (gates the shift clock)
- busy  out  1  high from accepted start until DONE exit
- done  out  1  one-cycle pulse at sequence end
- pat_idx  out  PAT_W  current pattern index, 0-based
- err  out  1  sticky capture-count mismatch; cleared on accepted start
- err_cnt  out  PAT_W  number of mismatching patterns; saturates at all-ones

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - se=1, shift_en=0, busy=0, done=0, pat_idx=0, err=0, err_cnt=0.
  - Internal counters and latched ats_mode are cleared.
- States: IDLE → SHIFT → PRE → CAPTURE → POST → (SHIFT | DONE) → IDLE.
- IDLE:
  - se=1.
  - start=1 with num_pat≠0: latch num_pat and ats_mode, clear err/err_cnt/pat_idx, go SHIFT; busy=1 from the next cycle.
  - start with num_pat=0: no effect.
- SHIFT:
  - se=1, shift_en=1 for exactly CHAIN_LEN cycles, then PRE.
- PRE:
  - se=1, shift_en=0 for SETTLE cycles, then CAPTURE.
- CAPTURE:
  - se=0 for exactly CAP_WIN cycles.
  - A 2-bit saturating counter counts rising edges of cap_en (cap_en=1 and previous sample 0). Max value 3.
  - A cap_en high on the first CAPTURE cycle counts as a rise only if it was 0 in the last PRE cycle.
- POST:
  - se=1 for SETTLE cycles.
  - On the first POST cycle, compare the edge count to expected (2 if latched ats_mode=1, else 1). On mismatch: err←1, err_cnt+1 (saturating).
  - Edge counter clears on POST exit.
  - At POST exit: if pat_idx == num_pat−1 go DONE; else pat_idx+1 and go SHIFT.
- DONE:
  - One cycle, done=1, busy=1, then IDLE (busy=0).
- Capture data of pattern N unloads during the shift of pattern N+1. The last pattern's unload is covered by the optional feature.
- start while busy: ignored.
- Latched num_pat/ats_mode do not change mid-sequence.
- cap_en activity outside CAPTURE: ignored; it does not count.
- Reset mid-sequence: immediate return to reset values; se goes 1 asynchronously.
- Cycles per pattern: CHAIN_LEN + 2·SETTLE + CAP_WIN. Defaults: 32.

Optional Feature:
- OCC_SEQ_FINAL_UNLOAD_EN
- Defined:
  - After the last pattern's POST, enter an UNLOAD state: se=1, shift_en=1 for CHAIN_LEN cycles, then DONE.
  - pat_idx holds num_pat−1 during UNLOAD.
- Undefined:
  - No UNLOAD state; POST goes directly to DONE.
  - Total sequence length is num_pat·32 + 1 cycles at defaults.

Test Plan:
- Reset checks:
  - Assert rst_n=0 mid-SHIFT → se=1, busy=0, shift_en=0 immediately.
  - Release, then start with num_pat=1 → sequence restarts cleanly from pat_idx=0.
- ats_mode=0, num_pat=1, cap_en pulses 1 cycle high at CAPTURE cycle 6:
  - se low exactly 12 cycles, 16 shift_en cycles.
  - done pulses 33 cycles after start (feature off); err=0.
- ats_mode=1, num_pat=3, cap_en gives 2 rises per window except pattern 1 (one rise):
  - err=1, err_cnt=1, pat_idx sequence 0,1,2, done after 3·32 + 1 cycles.
- start pulsed while busy, and start with num_pat=0 in IDLE → no state change, busy unchanged.
- cap_en high throughout PRE and CAPTURE (no rise):
  - Count 0 → mismatch flagged.
  - cap_en toggling during SHIFT/POST → not counted.
- With OCC_SEQ_FINAL_UNLOAD_EN, num_pat=2:
  - 16 extra shift_en cycles after the last POST.
  - done at 2·32 + 16 + 1 cycles after start.

Source files
------------

// File: rtl/occ_scan_sequencer.sv
// occ_scan_sequencer: drives the scan-enable waveform for the on-chip clock
// controller. Each pattern runs shift, pre-settle, capture and post-settle.
// During capture it counts rising edges of cap_en, and it flags any window
// whose pulse count is not the expected one (2 at-speed, 1 otherwise).
// Optional build macro OCC_SEQ_FINAL_UNLOAD_EN adds a final unload shift
// after the last pattern, so that pattern's capture data is shifted out.
module occ_scan_sequencer #(
  parameter int CHAIN_LEN = 16,
  parameter int CAP_WIN   = 12,
  parameter int SETTLE    = 2,
  parameter int PAT_W     = 8
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] num_pat,
  input  logic             ats_mode,
  input  logic             cap_en,
  output logic             se,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] pat_idx,
  output logic             err,
  output logic [PAT_W-1:0] err_cnt
);

  localparam int CW = $clog2(CHAIN_LEN + CAP_WIN + SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_PRE, S_CAP, S_POST, S_UNLOAD, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PAT_W-1:0] num_pat_q, pat_idx_q, err_cnt_q;
  logic [1:0]       edge_q;
  logic             ats_q, cap_prev_q, err_q;
  logic             se_q, shift_en_q, busy_q, done_q;
  logic             phase_end, last_pat, accept, cap_rise, mismatch;

  // Last cycle of the current timed phase.
  always_comb begin
    phase_end = 1'b0;
    unique case (state_q)
      S_SHIFT, S_UNLOAD: phase_end = (cnt_q == CW'(CHAIN_LEN - 1));
      S_PRE, S_POST:     phase_end = (cnt_q == CW'(SETTLE - 1));
      S_CAP:             phase_end = (cnt_q == CW'(CAP_WIN - 1));
      default:           phase_end = 1'b0;
    endcase
  end

  assign accept   = (state_q == S_IDLE) && start && (num_pat != '0);
  assign last_pat = (pat_idx_q == num_pat_q - PAT_W'(1));
  // The first capture cycle compares against the last PRE sample.
  assign cap_rise = (state_q == S_CAP) && cap_en && !cap_prev_q;
  // Evaluated once, on the first POST cycle, after the whole window has counted.
  assign mismatch = (state_q == S_POST) && (cnt_q == '0) &&
                    (edge_q != (ats_q ? 2'd2 : 2'd1));

  // Next-state selection; the phase counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_SHIFT;
      S_SHIFT:  if (phase_end) state_d = S_PRE;
      S_PRE:    if (phase_end) state_d = S_CAP;
      S_CAP:    if (phase_end) state_d = S_POST;
      S_POST:
        if (phase_end) begin
          if (!last_pat) state_d = S_SHIFT;
`ifdef OCC_SEQ_FINAL_UNLOAD_EN
          else           state_d = S_UNLOAD;
`else
          else           state_d = S_DONE;
`endif
        end
      S_UNLOAD: if (phase_end) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + CW'(1);
  end

  // State, counters, and outputs registered from the next state.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      num_pat_q  <= '0;
      pat_idx_q  <= '0;
      err_cnt_q  <= '0;
      edge_q     <= '0;
      ats_q      <= 1'b0;
      cap_prev_q <= 1'b0;
      err_q      <= 1'b0;
      se_q       <= 1'b1;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_prev_q <= cap_en;
      se_q       <= (state_d != S_CAP);
      shift_en_q <= (state_d == S_SHIFT) || (state_d == S_UNLOAD);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      if (accept) begin
        num_pat_q <= num_pat;
        ats_q     <= ats_mode;
        err_q     <= 1'b0;
        err_cnt_q <= '0;
        pat_idx_q <= '0;
      end
      if ((state_q == S_POST) && phase_end && !last_pat)
        pat_idx_q <= pat_idx_q + PAT_W'(1);
      if (cap_rise && (edge_q != 2'd3))
        edge_q <= edge_q + 2'd1;
      else if ((state_q == S_POST) && phase_end)
        edge_q <= '0;
      if (mismatch) begin
        err_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + PAT_W'(1);
      end
    end
  end

  assign se       = se_q;
  assign shift_en = shift_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pat_idx  = pat_idx_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule
